// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: assembles big-endian 16-bit words from a
// byte stream, writes them sequentially and releases the CPU after checksum verification.
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_run,
    output logic [ADDR_W:0]   word_count
);

    localparam int CW = ADDR_W + 1;
    localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CSUM, DONE, ERR
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    xor_acc;
    logic [7:0]    len_hi_q;
    logic [CW-1:0] len_q;
    logic [15:0]   len_in;
    logic [CW-1:0] wc_inc;
    logic          accept;

    assign accept = byte_valid & byte_ready;
    assign len_in = {len_hi_q, byte_data};
    assign wc_inc = word_count + CW'(1);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE, ERR: if (start) state_nxt = LEN_HI;
            LEN_HI:  if (accept) state_nxt = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if ({1'b0, len_in} > MAX_N) state_nxt = ERR;
                    else if (len_in == 16'd0)   state_nxt = CSUM;
                    else                        state_nxt = DATA_HI;
                end
            end
            DATA_HI: if (accept) state_nxt = DATA_LO;
            DATA_LO: if (accept) state_nxt = WRITE;
            WRITE:   state_nxt = (wc_inc == len_q) ? CSUM : DATA_HI;
            CSUM:    if (accept) state_nxt = (byte_data == xor_acc) ? DONE : ERR;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are registered decodes of the next state, so they line up
    // with the state register and never depend combinationally on byte_valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            xor_acc    <= '0;
            len_hi_q   <= '0;
            len_q      <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_run    <= 1'b0;
        end else begin
            state      <= state_nxt;
            byte_ready <= state_nxt inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM};
            mem_we     <= (state_nxt == WRITE);
            busy       <= !(state_nxt inside {IDLE, DONE, ERR});
            done       <= (state_nxt == DONE);
            error      <= (state_nxt == ERR);
            cpu_run    <= (state_nxt == DONE);

            unique case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        xor_acc    <= '0;
                        word_count <= '0;
                        mem_addr   <= '0;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len_hi_q <= byte_data;
                        xor_acc  <= xor_acc ^ byte_data;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len_q   <= CW'(len_in);
                        xor_acc <= xor_acc ^ byte_data;
                    end
                end
                DATA_HI: begin
                    if (accept) begin
                        mem_wdata[15:8] <= byte_data;
                        xor_acc         <= xor_acc ^ byte_data;
                    end
                end
                DATA_LO: begin
                    if (accept) begin
                        mem_wdata[7:0] <= byte_data;
                        xor_acc        <= xor_acc ^ byte_data;
                    end
                end
                WRITE: begin
                    mem_addr   <= mem_addr + ADDR_W'(1);
                    word_count <= wc_inc;
                end
                default: ;
            endcase
        end
    end

endmodule
